// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer around a Fibonacci LFSR with seeding and valid/ready output.
// Optional free-running LFSR in IDLE/FIN: define LFSR_BURST_CTRL_FREERUN_EN.
module lfsr_burst_ctrl #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_val_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] burst_len_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             lockup_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lockup_q, lockup_d;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lockup_d    = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
`ifdef LFSR_BURST_CTRL_FREERUN_EN
                state_d = lfsr_step(state_q);
`endif
                // Seed wins over start so the burst begins from the new seed.
                if (seed_load_i) begin
                    if (seed_val_i != '0) begin
                        state_d = seed_val_i;
                    end else begin
                        state_d  = SEED;
                        lockup_d = 1'b1;
                    end
                end
                if (start_i) begin
                    if (burst_len_i != '0) begin
                        remaining_d = burst_len_i;
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        fsm_d       = S_RUN;
                    end else begin
                        done_d = 1'b1;
                        fsm_d  = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (valid_q && out_ready_i) begin
                    state_d     = lfsr_step(state_q);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        fsm_d   = S_FIN;
                    end
                end
            end
            S_FIN: begin
`ifdef LFSR_BURST_CTRL_FREERUN_EN
                state_d = lfsr_step(state_q);
`endif
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= SEED;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lockup_q    <= lockup_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = state_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Scoreboard bench for lfsr_burst_ctrl: expected words queued at start,
// popped on every accepted handshake.
module tb_lfsr_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seed_load = 1'b0;
    logic [3:0] seed_val = '0;
    logic       start = 1'b0;
    logic [7:0] burst_len = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       busy;
    logic       done;
    logic       lockup;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    logic        done_prev = 1'b0;
    logic [15:0] seen = '0;
    logic [3:0]  mdl = 4'b0001;
    logic [3:0]  exp_q[$];

    lfsr_burst_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load_i(seed_load),
        .seed_val_i (seed_val),
        .start_i    (start),
        .burst_len_i(burst_len),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy),
        .done_o     (done),
        .lockup_o   (lockup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Taps 1001: feedback is bit3 xor bit0.
    function automatic logic [3:0] mstep(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
                seen[out_data] = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check("done_pulse", done_prev, 0);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [3:0] v);
        seed_load = 1'b1;
        seed_val  = v;
        tick();
        seed_load = 1'b0;
        mdl = (v != 0) ? v : 4'b0001;
    endtask

    task automatic queue_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mdl);
            mdl = mstep(mdl);
        end
    endtask

    task automatic pulse_start(input logic [7:0] n);
        start     = 1'b1;
        burst_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_valid_off"}, out_valid, 0);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_data_after"}, out_data, mdl);
        tick();
    endtask

    initial begin
        int d0;
        int v0;
        // Reset
        tick();
        tick();
        @(negedge clk);
        check("rst_data", out_data, 4'b0001);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lockup", lockup, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst of 4
        out_ready = 1'b1;
        do_seed(4'b0001);
        queue_words(4);
        pulse_start(8'd4);
        @(negedge clk);
        check("b4_busy", busy, 1);
        check("b4_first", out_data, 4'b0001);
        wait_done("b4");
        check("b4_end_data", out_data, 4'b1110);

        // Backpressure
        out_ready = 1'b0;
        do_seed(4'b0001);
        queue_words(3);
        pulse_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_hold", out_data, 4'b0001);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("bp");

        // Zero seed substitution
        do_seed(4'b0000);
        @(negedge clk);
        check("lk_pulse", lockup, 1);
        check("lk_data", out_data, 4'b0001);
        tick();
        @(negedge clk);
        check("lk_once", lockup, 0);
        queue_words(1);
        pulse_start(8'd1);
        wait_done("lk");

        // Full period
        do_seed(4'b0001);
        seen = '0;
        queue_words(15);
        pulse_start(8'd15);
        wait_done("p15");
        check("p15_distinct", seen, 16'hFFFE);
        check("p15_wrap", out_data, 4'b0001);

        // Zero length burst
        v0 = valid_cnt;
        d0 = done_cnt;
        pulse_start(8'd0);
        @(negedge clk);
        check("z_done", done, 1);
        tick();
        @(negedge clk);
        check("z_done_once", done, 0);
        check("z_no_valid", valid_cnt - v0, 0);
        check("z_done_cnt", done_cnt - d0, 1);
        tick();

        // Seed and start together
        seed_load = 1'b1;
        seed_val  = 4'b0101;
        mdl       = 4'b0101;
        queue_words(2);
        pulse_start(8'd2);
        seed_load = 1'b0;
        wait_done("ss");

        // Reset mid-burst
        do_seed(4'b0001);
        queue_words(8);
        pulse_start(8'd8);
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        mdl = 4'b0001;
        @(negedge clk);
        check("mr_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_data", out_data, 4'b0001);
        repeat (3) tick();
        check("mr_no_done", done_cnt - d0, 0);

        // Restart, with start and seed_load pulsed mid-burst
        out_ready = 1'b0;
        queue_words(3);
        pulse_start(8'd3);
        start     = 1'b1;
        burst_len = 8'd7;
        seed_load = 1'b1;
        seed_val  = 4'b1010;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b1;
        wait_done("rs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
